apb_fabric: RTL and testbench

Parametrised one-to-N APB interconnect between a single APB bridge and NUM_SLAVES peripherals. It decodes the latched transfer address against per-slave base/mask windows and replays the transfer on the selected downstream port. It returns the response upstream with a registered PREADY pulse. It adds decode-error and access-timeout responses, signalled via PSLVERR, that a point-to-point bridge/peripheral link cannot provide.

---
 rtl/apb_pkg.sv | 10 +
 rtl/apb_addr_decode.sv | 23 ++
 rtl/apb_fabric.sv | 133 +++++++++++++
 tb/tb_apb_fabric.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB bus defaults, fabric state encoding and index-width helper
package apb_pkg;
  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, DSETUP, DACCESS, RESP} fabric_state_e;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: base/mask window match, lowest matching slave index wins
module apb_addr_decode import apb_pkg::*; #(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int IW = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  output logic                  hit,
  output logic [IW-1:0]         idx
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((paddr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/apb_fabric.sv
// apb_fabric: one-to-N APB interconnect with registered response, decode-error
// and access-timeout reporting
module apb_fabric import apb_pkg::*; #(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             pclk,
  input  logic                             preset,
  input  logic [ADDR_WIDTH-1:0]            up_paddr,
  input  logic                             up_psel,
  input  logic                             up_penable,
  input  logic                             up_pwrite,
  input  logic [DATA_WIDTH-1:0]            up_pwdata,
  input  logic [STRB_WIDTH-1:0]            up_pstrb,
  input  logic [2:0]                       up_pprot,
  output logic [DATA_WIDTH-1:0]            up_prdata,
  output logic                             up_pready,
  output logic                             up_pslverr,
  output logic [NUM_SLAVES-1:0]            dn_psel,
  output logic [ADDR_WIDTH-1:0]            dn_paddr,
  output logic                             dn_penable,
  output logic                             dn_pwrite,
  output logic [DATA_WIDTH-1:0]            dn_pwdata,
  output logic [STRB_WIDTH-1:0]            dn_pstrb,
  output logic [2:0]                       dn_pprot,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] dn_prdata,
  input  logic [NUM_SLAVES-1:0]            dn_pready,
  input  logic [NUM_SLAVES-1:0]            dn_pslverr,
  output logic                             decerr_evt,
  output logic                             timeout_evt
);
  localparam int IW = idx_width(NUM_SLAVES);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  fabric_state_e state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [2:0] prot_q;
  logic [IW-1:0] idx_q, idx;
  logic [CW-1:0] cnt_q;
  logic write_q, err_q, dec_q, to_q, hit;
  logic setup, sel_ready, expire;
  logic [NUM_SLAVES-1:0] onehot;
  apb_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .NUM_SLAVES(NUM_SLAVES),
    .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK)
  ) u_decode (.paddr(up_paddr), .hit(hit), .idx(idx));
  assign setup = up_psel && !up_penable;
  assign sel_ready = dn_pready[idx_q];
  assign expire = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign onehot = NUM_SLAVES'(1) << idx_q;
  assign dn_paddr = addr_q;
  assign dn_pwrite = write_q;
  assign dn_pwdata = wdata_q;
  assign dn_pstrb = strb_q;
  assign dn_pprot = prot_q;
  assign up_prdata = up_pready ? rdata_q : '0;
  assign up_pslverr = up_pready && err_q;
  assign decerr_evt = up_pready && dec_q;
  assign timeout_evt = up_pready && to_q;
  always_comb begin
    state_n = state;
    dn_psel = '0;
    dn_penable = 1'b0;
    up_pready = 1'b0;
    case (state)
      IDLE: if (setup) state_n = hit ? DSETUP : RESP;
      DSETUP: begin
        dn_psel = onehot;
        state_n = DACCESS;
      end
      DACCESS: begin
        dn_psel = onehot;
        dn_penable = 1'b1;
        if (sel_ready || expire) state_n = RESP;
      end
      RESP: begin
        up_pready = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q <= '0;
      prot_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      write_q <= 1'b0;
      err_q <= 1'b0;
      dec_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && setup) begin
        addr_q <= up_paddr;
        write_q <= up_pwrite;
        wdata_q <= up_pwdata;
        strb_q <= up_pstrb;
        prot_q <= up_pprot;
        idx_q <= idx;
        cnt_q <= '0;
        rdata_q <= '0;
        err_q <= !hit;
        dec_q <= !hit;
        to_q <= 1'b0;
      end
      // ready on the final allowed cycle still wins over the timeout
      if (state == DACCESS) begin
        if (sel_ready) begin
          rdata_q <= write_q ? '0 : dn_prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
          err_q <= dn_pslverr[idx_q];
        end else if (expire) begin
          rdata_q <= '0;
          err_q <= 1'b1;
          to_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_fabric.sv
// tb_apb_fabric: randomized and directed checks of apb_fabric against a
// transaction-level model of decode, latency, data and error responses
module tb_apb_fabric;
  localparam int AW = 32, DW = 32, SW = 4, NS = 4, TO = 16;
  localparam logic [NS*AW-1:0] BASE = {32'h2000, 32'h2000, 32'h1000, 32'h0000};
  localparam logic [NS*AW-1:0] MASK = {32'hF000, 32'hFF00, 32'hF000, 32'hF000};
  logic [AW-1:0] base_t [NS] = '{32'h0000, 32'h1000, 32'h2000, 32'h2000};
  logic [AW-1:0] mask_t [NS] = '{32'hF000, 32'hF000, 32'hFF00, 32'hF000};
  logic pclk = 1'b0, preset = 1'b1;
  logic [AW-1:0] up_paddr = '0, dn_paddr;
  logic up_psel = 1'b0, up_penable = 1'b0, up_pwrite = 1'b0;
  logic [DW-1:0] up_pwdata = '0, up_prdata, dn_pwdata;
  logic [SW-1:0] up_pstrb = '0, dn_pstrb;
  logic [2:0] up_pprot = '0, dn_pprot;
  logic up_pready, up_pslverr, dn_penable, dn_pwrite, decerr_evt, timeout_evt;
  logic [NS-1:0] dn_psel, dn_pready, dn_pslverr;
  logic [NS*DW-1:0] dn_prdata;
  int checks = 0, errors = 0, quiet_bad = 0;
  int wait_n [NS];
  logic [DW-1:0] rd_val [NS];
  logic slv_err [NS];
  logic [NS-1:0] noise = '0;
  int acc_cnt = 0;
  logic [DW-1:0] last_wdata [NS];
  logic [SW-1:0] last_wstrb [NS];
  logic [2:0] last_prot [NS];

  apb_fabric #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .NUM_SLAVES(NS),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .up_paddr(up_paddr), .up_psel(up_psel), .up_penable(up_penable), .up_pwrite(up_pwrite),
    .up_pwdata(up_pwdata), .up_pstrb(up_pstrb), .up_pprot(up_pprot),
    .up_prdata(up_prdata), .up_pready(up_pready), .up_pslverr(up_pslverr),
    .dn_psel(dn_psel), .dn_paddr(dn_paddr), .dn_penable(dn_penable), .dn_pwrite(dn_pwrite),
    .dn_pwdata(dn_pwdata), .dn_pstrb(dn_pstrb), .dn_pprot(dn_pprot),
    .dn_prdata(dn_prdata), .dn_pready(dn_pready), .dn_pslverr(dn_pslverr),
    .decerr_evt(decerr_evt), .timeout_evt(timeout_evt)
  );

  always #5 pclk = ~pclk;

  // slave models: selected slave answers after wait_n access cycles; others toggle noise
  always @(posedge pclk) begin
    noise <= NS'($urandom);
    acc_cnt <= dn_penable ? acc_cnt + 1 : 0;
    for (int i = 0; i < NS; i++)
      if (dn_psel[i] && dn_penable && dn_pready[i] && dn_pwrite) begin
        last_wdata[i] <= dn_pwdata;
        last_wstrb[i] <= dn_pstrb;
        last_prot[i] <= dn_pprot;
      end
  end
  always_comb begin
    dn_pready = '0;
    dn_pslverr = '0;
    dn_prdata = '0;
    for (int i = 0; i < NS; i++) begin
      dn_pready[i] = dn_psel[i] ? (dn_penable && acc_cnt == wait_n[i]) : noise[i];
      dn_pslverr[i] = dn_psel[i] ? slv_err[i] : noise[i];
      dn_prdata[i*DW +: DW] = dn_psel[i] ? rd_val[i] : ~rd_val[i];
    end
  end

  task automatic do_xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                         input bit drop_psel, output logic [DW-1:0] rd, output logic err,
                         output int lat, output logic dec, output logic tout,
                         output logic [NS-1:0] sel1, output int en_cycles);
    up_paddr = a; up_pwrite = w; up_pwdata = wd; up_pstrb = 4'b1011; up_pprot = 3'b010;
    up_psel = 1'b1; up_penable = 1'b0;
    lat = 0; en_cycles = 0; sel1 = '0; rd = '0; err = 1'b0; dec = 1'b0; tout = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      @(posedge pclk); #1;
      up_penable = 1'b1;
      if (drop_psel && n == 2) up_psel = 1'b0;
      if (n == 1) sel1 = dn_psel;
      if (dn_penable) en_cycles++;
      if (!up_pready && (up_prdata !== '0 || up_pslverr !== 1'b0 || decerr_evt !== 1'b0 || timeout_evt !== 1'b0))
        quiet_bad++;
      if (up_pready) begin
        lat = n; rd = up_prdata; err = up_pslverr; dec = decerr_evt; tout = timeout_evt;
        break;
      end
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL xfer_bound addr=%h no up_pready within 64 cycles", a);
    end
    @(posedge pclk); #1;
    up_psel = 1'b0; up_penable = 1'b0;
  endtask

  // transaction-level expectation: first window that matches, then latency from slave waits
  task automatic ref_xfer(input logic [AW-1:0] a, input logic w, output int lat,
                          output logic [DW-1:0] rd, output logic err, output logic dec,
                          output logic tout, output logic [NS-1:0] sel);
    int s;
    s = -1;
    for (int i = 0; i < NS; i++)
      if ((a & mask_t[i]) == (base_t[i] & mask_t[i])) begin s = i; break; end
    dec = 1'b0; tout = 1'b0; rd = '0; sel = '0;
    if (s < 0) begin
      lat = 1; err = 1'b1; dec = 1'b1;
    end else begin
      sel[s] = 1'b1;
      if (wait_n[s] < TO) begin
        lat = 3 + wait_n[s]; err = slv_err[s]; rd = w ? '0 : rd_val[s];
      end else begin
        lat = TO + 2; err = 1'b1; tout = 1'b1;
      end
    end
  endtask

  task automatic set_slaves(input int w, input logic e);
    for (int i = 0; i < NS; i++) begin
      wait_n[i] = w; slv_err[i] = e; rd_val[i] = $urandom;
    end
  endtask

  task automatic test_reset;
    preset = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    checks++;
    if ({up_pready, up_pslverr, dn_penable, decerr_evt, timeout_evt} !== 5'b0 || up_prdata !== '0) begin
      errors++; $display("FAIL reset_up got rdy=%b err=%b data=%h", up_pready, up_pslverr, up_prdata);
    end
    checks++;
    if (dn_psel !== '0 || dn_paddr !== '0 || dn_pwdata !== '0) begin
      errors++; $display("FAIL reset_dn got sel=%b addr=%h wdata=%h exp 0", dn_psel, dn_paddr, dn_pwdata);
    end
    preset = 1'b0;
  endtask

  task automatic test_write_hit;
    logic [DW-1:0] rd; logic err, dec, tout; logic [NS-1:0] sel1; int lat, en;
    set_slaves(0, 1'b0);
    do_xfer(32'h1004, 1'b1, 32'hDEADBEEF, 0, rd, err, lat, dec, tout, sel1, en);
    checks++; if (sel1 !== 4'b0010) begin errors++; $display("FAIL wr_sel got %b exp 0010", sel1); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_lat got %0d exp 3", lat); end
    checks++; if (err !== 1'b0 || rd !== '0) begin errors++; $display("FAIL wr_resp got err=%b rd=%h exp 0/0", err, rd); end
    checks++;
    if (last_wdata[1] !== 32'hDEADBEEF || last_wstrb[1] !== 4'b1011 || last_prot[1] !== 3'b010) begin
      errors++; $display("FAIL wr_slave got %h/%b/%b exp deadbeef/1011/010", last_wdata[1], last_wstrb[1], last_prot[1]);
    end
  endtask

  task automatic test_read_wait;
    logic [DW-1:0] rd; logic err, dec, tout; logic [NS-1:0] sel1; int lat, en;
    set_slaves(0, 1'b0);
    wait_n[0] = 3; rd_val[0] = 32'h12345678;
    do_xfer(32'h0008, 1'b0, '0, 0, rd, err, lat, dec, tout, sel1, en);
    checks++; if (lat !== 6) begin errors++; $display("FAIL rd_lat got %0d exp 6", lat); end
    checks++; if (rd !== 32'h12345678 || err !== 1'b0) begin errors++; $display("FAIL rd_data got %h err=%b exp 12345678/0", rd, err); end
  endtask

  task automatic test_decerr;
    logic [DW-1:0] rd; logic err, dec, tout; logic [NS-1:0] sel1; int lat, en;
    set_slaves(0, 1'b0);
    do_xfer(32'h8000, 1'b0, '0, 0, rd, err, lat, dec, tout, sel1, en);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dec_lat got %0d exp 1", lat); end
    checks++;
    if (err !== 1'b1 || rd !== '0 || dec !== 1'b1 || tout !== 1'b0) begin
      errors++; $display("FAIL dec_resp got err=%b rd=%h dec=%b to=%b exp 1/0/1/0", err, rd, dec, tout);
    end
    checks++; if (sel1 !== '0 || en !== 0) begin errors++; $display("FAIL dec_nosel got sel=%b en=%0d exp 0/0", sel1, en); end
  endtask

  task automatic test_timeout;
    logic [DW-1:0] rd; logic err, dec, tout; logic [NS-1:0] sel1; int lat, en;
    set_slaves(0, 1'b0);
    wait_n[1] = 1000;
    do_xfer(32'h1010, 1'b0, '0, 0, rd, err, lat, dec, tout, sel1, en);
    checks++; if (en !== TO) begin errors++; $display("FAIL to_enable got %0d exp %0d", en, TO); end
    checks++; if (lat !== TO + 2) begin errors++; $display("FAIL to_lat got %0d exp %0d", lat, TO + 2); end
    checks++;
    if (err !== 1'b1 || tout !== 1'b1 || rd !== '0 || dec !== 1'b0) begin
      errors++; $display("FAIL to_resp got err=%b to=%b rd=%h dec=%b exp 1/1/0/0", err, tout, rd, dec);
    end
    wait_n[1] = TO - 1;
    do_xfer(32'h1010, 1'b0, '0, 0, rd, err, lat, dec, tout, sel1, en);
    checks++;
    if (lat !== TO + 2 || tout !== 1'b0 || err !== 1'b0 || rd !== rd_val[1]) begin
      errors++; $display("FAIL to_edge got lat=%0d to=%b err=%b rd=%h exp %0d/0/0/%h", lat, tout, err, rd, TO + 2, rd_val[1]);
    end
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] rd; logic err, dec, tout; logic [NS-1:0] sel1; int lat, en;
    set_slaves(0, 1'b0);
    wait_n[0] = 5;
    up_paddr = 32'h0008; up_pwrite = 1'b0; up_psel = 1'b1; up_penable = 1'b0;
    @(posedge pclk); #1; up_penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    checks++;
    if (dn_psel !== '0 || up_pready !== 1'b0 || dn_penable !== 1'b0) begin
      errors++; $display("FAIL rstmid got sel=%b rdy=%b en=%b exp 0/0/0", dn_psel, up_pready, dn_penable);
    end
    preset = 1'b0; up_psel = 1'b0; up_penable = 1'b0;
    do_xfer(32'h1004, 1'b1, 32'hCAFEF00D, 0, rd, err, lat, dec, tout, sel1, en);
    checks++;
    if (lat !== 3 || err !== 1'b0 || sel1 !== 4'b0010 || last_wdata[1] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rstmid_next got lat=%0d err=%b sel=%b wd=%h exp 3/0/0010/cafef00d", lat, err, sel1, last_wdata[1]);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] rd; logic err, dec, tout; logic [NS-1:0] sel1; int lat, en;
    set_slaves(0, 1'b1);
    do_xfer(32'h1020, 1'b1, 32'h0BADCAFE, 0, rd, err, lat, dec, tout, sel1, en);
    checks++; if (lat !== 3 || err !== 1'b1) begin errors++; $display("FAIL b2b_wr got lat=%0d err=%b exp 3/1", lat, err); end
    do_xfer(32'h1024, 1'b0, '0, 0, rd, err, lat, dec, tout, sel1, en);
    checks++;
    if (lat !== 3 || err !== 1'b1 || rd !== rd_val[1]) begin
      errors++; $display("FAIL b2b_rd got lat=%0d err=%b rd=%h exp 3/1/%h", lat, err, rd, rd_val[1]);
    end
  endtask

  task automatic test_overlap_and_drop;
    logic [DW-1:0] rd; logic err, dec, tout; logic [NS-1:0] sel1; int lat, en;
    set_slaves(1, 1'b0);
    do_xfer(32'h2040, 1'b0, '0, 0, rd, err, lat, dec, tout, sel1, en);
    checks++; if (sel1 !== 4'b0100 || rd !== rd_val[2]) begin errors++; $display("FAIL ovl_low got sel=%b rd=%h exp 0100/%h", sel1, rd, rd_val[2]); end
    do_xfer(32'h2140, 1'b0, '0, 0, rd, err, lat, dec, tout, sel1, en);
    checks++; if (sel1 !== 4'b1000 || rd !== rd_val[3]) begin errors++; $display("FAIL ovl_high got sel=%b rd=%h exp 1000/%h", sel1, rd, rd_val[3]); end
    wait_n[0] = 2;
    do_xfer(32'h0100, 1'b0, '0, 1, rd, err, lat, dec, tout, sel1, en);
    checks++; if (lat !== 5 || rd !== rd_val[0]) begin errors++; $display("FAIL drop_psel got lat=%0d rd=%h exp 5/%h", lat, rd, rd_val[0]); end
  endtask

  task automatic test_random;
    logic [DW-1:0] rd, erd; logic err, dec, tout, eerr, edec, etout, w; logic [NS-1:0] sel1, esel;
    logic [AW-1:0] a, wd; int lat, en, elat, r;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NS; i++) begin
        r = $urandom_range(0, 9);
        wait_n[i] = r == 0 ? 500 : r == 1 ? TO - 1 : $urandom_range(0, 4);
        slv_err[i] = 1'($urandom); rd_val[i] = $urandom;
      end
      r = $urandom_range(0, 5);
      a = $urandom;
      if (r < 5) a = {16'h0, r == 3 ? (16'h2000 | 16'(a[11:8] == 0 ? 1 : a[11:8]) << 8 | 16'(a[7:0]))
                       : r == 4 ? (16'h8000 | 16'(a[11:0])) : ((16'(r) << 12) | 16'(a[11:0]))};
      w = 1'($urandom); wd = $urandom;
      ref_xfer(a, w, elat, erd, eerr, edec, etout, esel);
      do_xfer(a, w, wd, 0, rd, err, lat, dec, tout, sel1, en);
      checks++;
      if (lat !== elat || rd !== erd || err !== eerr || dec !== edec || tout !== etout || sel1 !== esel) begin
        errors++;
        $display("FAIL rand[%0d] a=%h w=%b got lat=%0d rd=%h err=%b dec=%b to=%b sel=%b exp %0d/%h/%b/%b/%b/%b",
                 k, a, w, lat, rd, err, dec, tout, sel1, elat, erd, eerr, edec, etout, esel);
      end
      if (w && esel != '0 && !etout) begin
        checks++;
        for (int i = 0; i < NS; i++)
          if (esel[i] && last_wdata[i] !== wd) begin
            errors++; $display("FAIL rand_wdata[%0d] got %h exp %h", k, last_wdata[i], wd);
          end
      end
    end
    checks++;
    if (quiet_bad !== 0) begin errors++; $display("FAIL quiet_outputs got %0d nonzero idle samples exp 0", quiet_bad); end
  endtask

  initial begin
    set_slaves(0, 1'b0);
    test_reset;
    test_write_hit;
    test_read_wait;
    test_decerr;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    test_overlap_and_drop;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
